// File: rtl/exec_pkg.sv
// Shared types and codes for the EX stage: ALU control, decode field codes,
// forwarding selects and the handshake FSM state encoding.
package exec_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } ex_state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EX_MEM  = 2'b01;
    localparam logic [1:0] FWD_MEM_WB  = 2'b10;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // True for operations that go through the iterative multiply/divide unit
    function automatic logic is_md(input alu_ctrl_e c);
        return c inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply and restoring divide on operand
// magnitudes, MD_RADIX bits per cycle, sign fixup applied on the final step.
// Divide-by-zero and signed overflow never reach this block.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MD_RADIX = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill_i,
    input  logic            start_i,
    input  alu_ctrl_e       op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int MD_CYCLES = XLEN / MD_RADIX;
    localparam int CW        = $clog2(MD_CYCLES + 1);

    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, neg_q;
    alu_ctrl_e       op_q;

    logic            a_sgn, b_sgn, neg_d;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_op;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem;

    assign div_op = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign done_o = busy_q && (cnt_q == CW'(MD_CYCLES - 1));

    // Operand magnitudes and the sign the final result must carry
    always_comb begin
        a_sgn = (op_i inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a_i[XLEN-1];
        b_sgn = (op_i inside {ALU_MULH, ALU_DIV, ALU_REM}) && b_i[XLEN-1];
        a_mag = a_sgn ? -a_i : a_i;
        b_mag = b_sgn ? -b_i : b_i;
        case (op_i)
            ALU_MULH, ALU_DIV:   neg_d = a_sgn ^ b_sgn;
            ALU_MULHSU, ALU_REM: neg_d = a_sgn;
            default:             neg_d = 1'b0;
        endcase
    end

    // One cycle of iteration: MD_RADIX multiply or divide steps on {hi, lo}
    always_comb begin : iter_step
        logic [XLEN-1:0] h, l;
        logic [XLEN:0]   t;
        h = hi_q;
        l = lo_q;
        t = '0;
        for (int k = 0; k < MD_RADIX; k++) begin
            if (div_op) begin
                t = {h, l[XLEN-1]} - {1'b0, b_q};
                if (!t[XLEN]) h = t[XLEN-1:0];
                else          h = {h[XLEN-2:0], l[XLEN-1]};
                l = {l[XLEN-2:0], ~t[XLEN]};
            end else begin
                t = {1'b0, h} + (l[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
                h = t[XLEN:1];
                l = {t[0], l[XLEN-1:1]};
            end
        end
        hi_d = h;
        lo_d = l;
    end

    // Sign fixup and result selection from the post-step registers
    always_comb begin
        prod = {hi_d, lo_d};
        if (neg_q) prod = -prod;
        quo = neg_q ? -lo_d : lo_d;
        rem = neg_q ? -hi_d : hi_d;
        case (op_q)
            ALU_MUL:                          result_o = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  result_o = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                result_o = quo;
            default:                          result_o = rem;
        endcase
    end

    // Load on start, iterate while busy, abort on kill or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            op_q   <= ALU_MUL;
        end else if (kill_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            hi_q   <= '0;
            lo_q   <= a_mag;
            b_q    <= b_mag;
            neg_q  <= neg_d;
            op_q   <= op_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_unit_md.sv
// EX stage: operand forwarding, RV32I/RV32M decode, single-cycle ALU, the
// valid/ready handshake FSM and the registered EX/MEM-facing outputs.
module execute_unit_md
    import exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MD_RADIX = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] immediate,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] mem_wb_write_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] rs2_data_out,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    ex_state_e       state_q;
    logic            out_valid_q, busy_q;
    logic [XLEN-1:0] result_q, rs2_q;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, spec_res, single_res;
    alu_ctrl_e       ctrl;
    logic            md_op, md_special, div_zero, div_ovf;
    logic            accept, md_start, md_done;
    logic [XLEN-1:0] md_result;

    function automatic alu_ctrl_e decode(input logic [1:0] aop, input logic [2:0] f3,
                                         input logic [6:0] f7);
        alu_ctrl_e c;
        c = ALU_ADD;
        case (aop)
            ALUOP_SUB: c = ALU_SUB;
            ALUOP_RTYPE: begin
                if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'b000:  c = ALU_MUL;
                        3'b001:  c = ALU_MULH;
                        3'b010:  c = ALU_MULHSU;
                        3'b011:  c = ALU_MULHU;
                        3'b100:  c = ALU_DIV;
                        3'b101:  c = ALU_DIVU;
                        3'b110:  c = ALU_REM;
                        default: c = ALU_REMU;
                    endcase
                end else if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  c = ALU_ADD;
                        3'b001:  c = ALU_SLL;
                        3'b010:  c = ALU_SLT;
                        3'b011:  c = ALU_SLTU;
                        3'b100:  c = ALU_XOR;
                        3'b101:  c = ALU_SRL;
                        3'b110:  c = ALU_OR;
                        default: c = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      c = ALU_SUB;
                    else if (f3 == 3'b101) c = ALU_SRA;
                end
            end
            ALUOP_ITYPE: begin
                case (f3)
                    3'b000:  c = ALU_ADD;
                    3'b001:  c = ALU_SLL;
                    3'b010:  c = ALU_SLT;
                    3'b011:  c = ALU_SLTU;
                    3'b100:  c = ALU_XOR;
                    3'b101:  c = f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  c = ALU_OR;
                    default: c = ALU_AND;
                endcase
            end
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    function automatic logic [XLEN-1:0] alu_compute(input alu_ctrl_e c,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (c)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    // Operand forwarding and immediate selection
    always_comb begin
        case (forward_a)
            FWD_EX_MEM: op_a = ex_mem_alu_result;
            FWD_MEM_WB: op_a = mem_wb_write_data;
            default:    op_a = rs1_data;
        endcase
        case (forward_b)
            FWD_EX_MEM: fwd_b = ex_mem_alu_result;
            FWD_MEM_WB: fwd_b = mem_wb_write_data;
            default:    fwd_b = rs2_data;
        endcase
        op_b = alu_src ? immediate : fwd_b;
    end

    assign ctrl     = decode(alu_op, funct3, funct7);
    assign md_op    = is_md(ctrl);
    assign alu_res  = alu_compute(ctrl, op_a, op_b);
    assign div_zero = (op_b == '0);
    assign div_ovf  = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    // Divide corner cases resolved in one cycle without iterating
    always_comb begin
        md_special = 1'b0;
        spec_res   = '0;
        case (ctrl)
            ALU_DIV: begin
                if (div_zero)     begin md_special = 1'b1; spec_res = '1;   end
                else if (div_ovf) begin md_special = 1'b1; spec_res = op_a; end
            end
            ALU_DIVU: if (div_zero) begin md_special = 1'b1; spec_res = '1; end
            ALU_REM: begin
                if (div_zero)     begin md_special = 1'b1; spec_res = op_a; end
                else if (div_ovf) begin md_special = 1'b1; spec_res = '0;   end
            end
            ALU_REMU: if (div_zero) begin md_special = 1'b1; spec_res = op_a; end
            default: ;
        endcase
    end

    assign single_res = md_special ? spec_res : alu_res;
    assign in_ready   = (state_q != ST_CALC) && (!out_valid_q || out_ready) && !flush;
    assign accept     = in_valid && in_ready;
    assign md_start   = accept && md_op && !md_special;

    muldiv_iter #(
        .XLEN     (XLEN),
        .MD_RADIX (MD_RADIX)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (reset),
        .kill_i   (flush),
        .start_i  (md_start),
        .op_i     (ctrl),
        .a_i      (op_a),
        .b_i      (op_b),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Handshake FSM with registered result, store data, valid and busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            rs2_q       <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            rs2_q <= fwd_b;
            if (md_op && !md_special) begin
                state_q     <= ST_CALC;
                busy_q      <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= ST_DONE;
                result_q    <= single_res;
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_CALC: begin
                    if (md_done) begin
                        state_q     <= ST_DONE;
                        result_q    <= md_result;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign alu_result   = result_q;
    assign rs2_data_out = rs2_q;

endmodule

// File: tb/tb_execute_unit_md.sv
// Self-checking bench for execute_unit_md: directed corner cases plus
// randomized operations compared against a behavioural reference model.
module tb_execute_unit_md;

    localparam int XLEN      = 32;
    localparam int MD_CYCLES = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] rs1_data, rs2_data, immediate;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            alu_src;
    logic [1:0]      alu_op, forward_a, forward_b;
    logic [XLEN-1:0] ex_mem_alu_result, mem_wb_write_data;
    logic            flush, out_valid, out_ready;
    logic [XLEN-1:0] alu_result, rs2_data_out;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    execute_unit_md #(.XLEN(XLEN), .MD_RADIX(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .immediate         (immediate),
        .funct3            (funct3),
        .funct7            (funct7),
        .alu_src           (alu_src),
        .alu_op            (alu_op),
        .forward_a         (forward_a),
        .forward_b         (forward_b),
        .ex_mem_alu_result (ex_mem_alu_result),
        .mem_wb_write_data (mem_wb_write_data),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .alu_result        (alu_result),
        .rs2_data_out      (rs2_data_out),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference result straight from the RV32I/M definitions
    function automatic logic [31:0] ref_exec(input logic [1:0] aop, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] a,
                                             input logic [31:0] b);
        longint p;
        logic [4:0] s;
        logic ovf;
        s   = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (aop == 2'b00) return a + b;
        if (aop == 2'b01) return a - b;
        if (aop == 2'b10 && f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
                3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
                3'd2: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
                3'd3: begin p = longint'({32'd0, a} * {32'd0, b}); return p[63:32]; end
                3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
                3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
                default: return (b == 0) ? a : a % b;
            endcase
        end
        if (aop == 2'b10 && f7 == 7'h20) begin
            if (f3 == 3'd0) return a - b;
            if (f3 == 3'd5) return 32'($signed(a) >>> s);
            return a + b;
        end
        if (aop == 2'b10 && f7 != 7'h00) return a + b;
        case (f3)
            3'd0: return a + b;
            3'd1: return a << s;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (aop == 2'b11 && f7[5]) ? 32'($signed(a) >>> s) : a >> s;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] aop, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b);
        logic special;
        if (!(aop == 2'b10 && f7 == 7'h01)) return 1;
        special = (f3 >= 3'd4) && ((b == 0) ||
                  ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return special ? 1 : MD_CYCLES + 1;
    endfunction

    function automatic logic [31:0] fwd_sel(input logic [1:0] f, input logic [31:0] rf);
        if (f == 2'b01) return ex_mem_alu_result;
        if (f == 2'b10) return mem_wb_write_data;
        return rf;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic src, input logic [1:0] fa, input logic [1:0] fb);
        alu_op = aop; funct3 = f3; funct7 = f7;
        rs1_data = r1; rs2_data = r2; immediate = imm;
        alu_src = src; forward_a = fa; forward_b = fb;
        in_valid = 1'b1;
    endtask

    task automatic accept_op(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk({tag, ":accept"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat, output logic [31:0] res);
        int lat = 1;
        while (!out_valid && lat < 200) begin
            if (lat == 2) begin
                chk({tag, ":in_ready_low"}, 32'(in_ready), 32'd0);
                chk({tag, ":busy"}, 32'(busy), 32'd1);
            end
            step();
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        res = alu_result;
    endtask

    task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic src, input logic [1:0] fa,
                          input logic [1:0] fb, output logic [31:0] res);
        logic [31:0] ea, efb, eb;
        ea  = fwd_sel(fa, r1);
        efb = fwd_sel(fb, r2);
        eb  = src ? imm : efb;
        drive(aop, f3, f7, r1, r2, imm, src, fa, fb);
        accept_op(tag);
        wait_out(tag, ref_lat(aop, f3, f7, ea, eb), res);
        chk({tag, ":result"}, res, ref_exec(aop, f3, f7, ea, eb));
        chk({tag, ":rs2_out"}, rs2_data_out, efb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic        seen;
        logic [31:0] xa [4];
        logic [31:0] xb [4];
        logic [2:0]  xf [4];

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1_data = '0; rs2_data = '0; immediate = '0; funct3 = '0; funct7 = '0;
        alu_src = 1'b0; alu_op = '0; forward_a = '0; forward_b = '0;
        ex_mem_alu_result = '0; mem_wb_write_data = '0;

        repeat (3) step();
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:alu_result", alu_result, 32'd0);
        chk("rst:rs2_out", rs2_data_out, 32'd0);
        reset = 1'b1;
        step();
        chk("idle:in_ready", 32'(in_ready), 32'd1);

        ex_mem_alu_result = 32'd100;
        mem_wb_write_data = 32'd55;
        run_op("fwd_add", 2'b00, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 1'b0, 2'b01, 2'b00, res);
        chk("fwd_add:lit", res, 32'd107);
        run_op("srai", 2'b11, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00, res);
        chk("srai:lit", res, 32'hF800_0000);

        run_op("mul", 2'b10, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("mul:lit", res, 32'hFFFF_FFFE);
        run_op("mulhu", 2'b10, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("mulhu:lit", res, 32'd1);
        run_op("mulh", 2'b10, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("mulh:lit", res, 32'hFFFF_FFFF);

        run_op("div", 2'b10, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("div:lit", res, 32'hFFFF_FFFD);
        run_op("rem", 2'b10, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("rem:lit", res, 32'hFFFF_FFFF);
        run_op("divu0", 2'b10, 3'd5, 7'h01, 32'd7, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("divu0:lit", res, 32'hFFFF_FFFF);
        run_op("remu0", 2'b10, 3'd7, 7'h01, 32'd7, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("remu0:lit", res, 32'd7);
        run_op("divovf", 2'b10, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("divovf:lit", res, 32'h8000_0000);
        run_op("removf", 2'b10, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("removf:lit", res, 32'd0);

        // back-to-back single-cycle ops, one result per cycle
        xa = '{32'd11, 32'hF0F0_0000, 32'd3, 32'h8000_0001};
        xb = '{32'd22, 32'h0F0F_FFFF, 32'd5, 32'd1};
        xf = '{3'd0, 3'd4, 3'd1, 3'd5};
        step();
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, xf[i], 7'h00, xa[i], xb[i], 32'd0, 1'b0, 2'b00, 2'b00);
            chk("b2b:in_ready", 32'(in_ready), 32'd1);
            step();
            chk("b2b:out_valid", 32'(out_valid), 32'd1);
            chk("b2b:result", alu_result, ref_exec(2'b10, xf[i], 7'h00, xa[i], xb[i]));
        end
        in_valid = 1'b0;
        step();

        // output held while the consumer stalls
        out_ready = 1'b0;
        drive(2'b00, 3'd0, 7'h00, 32'd10, 32'd20, 32'd0, 1'b0, 2'b00, 2'b00);
        accept_op("hold");
        wait_out("hold", 1, res);
        drive(2'b01, 3'd0, 7'h00, 32'd50, 32'd8, 32'd0, 1'b0, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            chk("hold:in_ready", 32'(in_ready), 32'd0);
            chk("hold:out_valid", 32'(out_valid), 32'd1);
            chk("hold:result", alu_result, 32'd30);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("release:in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("release:out_valid", 32'(out_valid), 32'd1);
        chk("release:result", alu_result, 32'd42);
        step();

        // flush in the middle of a divide
        drive(2'b10, 3'd4, 7'h01, 32'd1000, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00);
        accept_op("flushdiv");
        repeat (9) step();
        flush = 1'b1;
        drive(2'b00, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00);
        #1;
        chk("flush:in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush:busy", 32'(busy), 32'd0);
        chk("flush:out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("flush:never_valid", 32'(seen), 32'd0);
        run_op("postflush", 2'b00, 3'd0, 7'h00, 32'd123, 32'd877, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("postflush:lit", res, 32'd1000);

        // asynchronous reset during a multiply
        drive(2'b10, 3'd0, 7'h01, 32'h1234, 32'h5678, 32'd0, 1'b0, 2'b00, 2'b00);
        accept_op("rstmul");
        repeat (5) step();
        reset = 1'b0;
        #1;
        chk("midrst:out_valid", 32'(out_valid), 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:alu_result", alu_result, 32'd0);
        chk("midrst:rs2_out", rs2_data_out, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        run_op("mul34", 2'b10, 3'd0, 7'h01, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, res);
        chk("mul34:lit", res, 32'd12);

        // randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [1:0] aop, fa, fb;
            logic [2:0] f3;
            logic [6:0] f7;
            logic       src;
            aop = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            src = (aop == 2'b11) ? 1'b1 : (aop == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
            fa  = 2'($urandom_range(0, 3));
            fb  = 2'($urandom_range(0, 3));
            ex_mem_alu_result = pick_val();
            mem_wb_write_data = pick_val();
            run_op("rand", aop, f3, f7, pick_val(), pick_val(), pick_val(), src, fa, fb, res);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
